// File: rtl/pic8259a_core.sv
// pic8259a_core: single-chip 8259A-compatible interrupt controller core.
// Ports: clk, rst_n (async active-low); cs_n/wr_n/rd_n/a0/din CPU bus;
// ir[7:0] requests; inta_n acknowledge; dout/dout_en read data or vector;
// int_o interrupt request to the CPU.
// Define PIC_ROTATE_EN to enable priority rotation commands.
module pic8259a_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic [7:0] ir,
    input  logic       inta_n,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic       int_o
);
    localparam logic [2:0] S_ICW1 = 3'd0, S_ICW2 = 3'd1, S_ICW3 = 3'd2, S_ICW4 = 3'd3, S_READY = 3'd4;

    logic [2:0] state_q, state_d, base_q, base_d, v_q, v_d, eoi_lvl, c_rank, s_rank;
    logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d, sfnm_q, sfnm_d, aeoi_q, aeoi_d;
    logic       rsel_q, rsel_d, raeoi_q, raeoi_d, vld_q, vld_d, int_q, int_d;
    logic [4:0] t_q, t_d;
    logic [7:0] icw3_q, icw3_d, imr_q, imr_d, isr_q, isr_d, irr_q, irr_d, ir_q, ir_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_n_q, inta_n_q, wr_stb, inta_fall, inta_rise, cpu_rd, vec_en, unused_ok;
    logic [3:0] cand, isr_hp, eoi_hp;

    // {found, level} of the highest-priority set bit, priority descending from base b
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] b);
        logic [15:0] r;
        logic [3:0]  res;
        r = {v, v} >> b;
        res = 4'd0;
        for (int i = 7; i >= 0; i--)
            if (r[i]) res = {1'b1, 3'(i) + b};
        return res;
    endfunction

    assign wr_stb    = !cs_n && wr_n_q && !wr_n;
    assign inta_fall = inta_n_q && !inta_n;
    assign inta_rise = !inta_n_q && inta_n;
    assign cpu_rd    = !cs_n && !rd_n && inta_n;
    // vector is driven from the second INTA falling edge until inta_n returns high
    assign vec_en    = !inta_n && (cnt_q == 2'd2 || (cnt_q == 2'd1 && inta_n_q));
    assign dout_en   = vec_en || cpu_rd;
    assign dout      = vec_en ? {t_q, v_q} : !cpu_rd ? 8'h00 : a0 ? imr_q : rsel_q ? isr_q : irr_q;
    assign int_o     = int_q;
    assign cand      = pick(irr_q & ~imr_q, base_q);
    assign isr_hp    = pick(isr_q, base_q);
    assign c_rank    = cand[2:0] - base_q;
    assign s_rank    = isr_hp[2:0] - base_q;
    assign unused_ok = ^{icw3_q, sfnm_q};

    always_comb begin
        state_d = state_q;
        ltim_d  = ltim_q;
        sngl_d  = sngl_q;
        ic4_d   = ic4_q;
        sfnm_d  = sfnm_q;
        aeoi_d  = aeoi_q;
        t_d     = t_q;
        icw3_d  = icw3_q;
        imr_d   = imr_q;
        isr_d   = isr_q;
        rsel_d  = rsel_q;
        raeoi_d = raeoi_q;
        base_d  = base_q;
        vld_d   = vld_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        eoi_lvl = 3'd0;
        ir_d    = ir;
        // edge mode keeps a request only while the line stays high
        irr_d   = ltim_q ? ir : (irr_q | (ir & ~ir_q)) & ir;
        if (inta_fall && cnt_q == 2'd0) begin
            cnt_d = 2'd1;
            vld_d = cand[3];
            v_d   = cand[3] ? cand[2:0] : 3'd7;
            if (cand[3]) begin
                isr_d[cand[2:0]] = 1'b1;
                if (!ltim_q) irr_d[cand[2:0]] = 1'b0;
            end
        end else if (inta_fall && cnt_q == 2'd1)
            cnt_d = 2'd2;
        else if (inta_rise && cnt_q == 2'd2) begin
            cnt_d = 2'd0;
            if (aeoi_q && vld_q) begin
                isr_d[v_q] = 1'b0;
`ifdef PIC_ROTATE_EN
                if (raeoi_q) base_d = v_q + 3'd1;
`endif
            end
        end
        // EOI sees the ISR after any same-cycle INTA update
        eoi_hp = pick(isr_d, base_q);
        if (wr_stb) begin
            if (!a0 && din[4]) begin
                state_d = S_ICW2;
                ltim_d  = din[3];
                sngl_d  = din[1];
                ic4_d   = din[0];
                sfnm_d  = 1'b0;
                aeoi_d  = 1'b0;
                imr_d   = 8'h00;
                isr_d   = 8'h00;
                irr_d   = 8'h00;
                ir_d    = 8'h00;
                raeoi_d = 1'b0;
                base_d  = 3'd0;
                rsel_d  = 1'b0;
                cnt_d   = 2'd0;
                vld_d   = 1'b0;
            end else if (a0 && state_q == S_ICW2) begin
                t_d     = din[7:3];
                state_d = !sngl_q ? S_ICW3 : ic4_q ? S_ICW4 : S_READY;
            end else if (a0 && state_q == S_ICW3) begin
                icw3_d  = din;
                state_d = ic4_q ? S_ICW4 : S_READY;
            end else if (a0 && state_q == S_ICW4) begin
                sfnm_d  = din[4];
                aeoi_d  = din[1];
                state_d = S_READY;
            end else if (state_q == S_READY) begin
                if (a0)
                    imr_d = din;
                else if (!din[3]) begin
                    if (din[5]) begin
                        eoi_lvl = din[6] ? din[2:0] : eoi_hp[2:0];
                        if (din[6] || eoi_hp[3]) begin
                            isr_d[eoi_lvl] = 1'b0;
`ifdef PIC_ROTATE_EN
                            if (din[7]) base_d = eoi_lvl + 3'd1;
`endif
                        end
                    end
`ifdef PIC_ROTATE_EN
                    else if (din[7:6] == 2'b11)
                        base_d = din[2:0] + 3'd1;
                    else if (!din[6])
                        raeoi_d = din[7];
`endif
                end else if (din[1])
                    rsel_d = din[0];
            end
        end
        int_d = state_d == S_READY && !(inta_fall && cnt_q == 2'd0) && cand[3] &&
                (!isr_hp[3] || c_rank < s_rank);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ICW1;
            ltim_q   <= 1'b0;
            sngl_q   <= 1'b0;
            ic4_q    <= 1'b0;
            sfnm_q   <= 1'b0;
            aeoi_q   <= 1'b0;
            t_q      <= 5'd0;
            icw3_q   <= 8'h00;
            imr_q    <= 8'h00;
            isr_q    <= 8'h00;
            irr_q    <= 8'h00;
            ir_q     <= 8'h00;
            rsel_q   <= 1'b0;
            raeoi_q  <= 1'b0;
            base_q   <= 3'd0;
            vld_q    <= 1'b0;
            v_q      <= 3'd0;
            cnt_q    <= 2'd0;
            int_q    <= 1'b0;
            wr_n_q   <= 1'b0;
            inta_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ltim_q   <= ltim_d;
            sngl_q   <= sngl_d;
            ic4_q    <= ic4_d;
            sfnm_q   <= sfnm_d;
            aeoi_q   <= aeoi_d;
            t_q      <= t_d;
            icw3_q   <= icw3_d;
            imr_q    <= imr_d;
            isr_q    <= isr_d;
            irr_q    <= irr_d;
            ir_q     <= ir_d;
            rsel_q   <= rsel_d;
            raeoi_q  <= raeoi_d;
            base_q   <= base_d;
            vld_q    <= vld_d;
            v_q      <= v_d;
            cnt_q    <= cnt_d;
            int_q    <= int_d;
            wr_n_q   <= wr_n;
            inta_n_q <= inta_n;
        end
    end
endmodule

// File: tb/tb_pic8259a_core.sv
// tb_pic8259a_core: directed and randomized checks of pic8259a_core against a behavioural model.
module tb_pic8259a_core;
    logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
    logic [7:0] din = 8'h00, ir = 8'h00, dout;
    logic       dout_en, int_o;
    int         n_cmp = 0, n_bad = 0;
    int         c, s, op;
    logic [7:0] m_imr, m_isr, rv, vec;
    logic [4:0] m_t;
    logic [2:0] m_base, l;
    logic       ren, mid, e;

    always #5 clk = ~clk;

    pic8259a_core dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
        .din(din), .ir(ir), .inta_n(inta_n), .dout(dout), .dout_en(dout_en), .int_o(int_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, want);
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd(input logic a, output logic [7:0] v, output logic en);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        #1;
        v = dout; en = dout_en;
        rd_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic inta(output logic [7:0] v, output logic en, output logic int_mid);
        @(negedge clk) inta_n = 1'b0;
        repeat (2) @(negedge clk);
        int_mid = int_o;
        inta_n = 1'b1;
        repeat (2) @(negedge clk);
        inta_n = 1'b0;
        repeat (2) @(negedge clk);
        v = dout; en = dout_en;
        inta_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    // priority search straight from the rule: B, B+1, ... mod 8; 8 means none
    function automatic int hp(input logic [7:0] v, input logic [2:0] b);
        for (int k = 0; k < 8; k++)
            if (v[(b + k) % 8]) return (b + k) % 8;
        return 8;
    endfunction

    function automatic logic want_int(input logic [7:0] req, input logic [7:0] isr, input logic [2:0] b);
        int cc, ss;
        cc = hp(req, b);
        ss = hp(isr, b);
        return cc != 8 && (ss == 8 || (cc - b + 8) % 8 < (ss - b + 8) % 8);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_int", int_o, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_en", dout_en, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        wr(0, 8'h13); wr(1, 8'h90); wr(1, 8'h02); wr(1, 8'h0F); wr(0, 8'h00); wr(0, 8'h0B);
        ir = 8'hAA; settle();
        chk("basic_int", int_o, 8'h01);
        inta(vec, ren, mid);
        chk("basic_int_mid_inta", mid, 8'h00);
        chk("basic_vec", vec, 8'h95);
        chk("basic_vec_en", ren, 8'h01);
        rd(0, rv, ren);
        chk("basic_isr_aeoi", rv, 8'h00);
        chk("basic_rd_en", ren, 8'h01);
        ir = 8'h00; settle();

        wr(0, 8'h13); wr(1, 8'h90); wr(1, 8'h00); wr(0, 8'h0B);
        ir = 8'h20; settle();
        chk("nest_int5", int_o, 8'h01);
        inta(vec, ren, mid);
        chk("nest_vec", vec, 8'h95);
        rd(0, rv, ren);
        chk("nest_isr", rv, 8'h20);
        ir = 8'h22; settle();
        chk("nest_int1", int_o, 8'h01);
        ir = 8'h20; settle();
        chk("nest_ir1_drop", int_o, 8'h00);
        ir = 8'h60; settle();
        chk("nest_int6_blocked", int_o, 8'h00);
        wr(0, 8'h20); settle();
        rd(0, rv, ren);
        chk("nest_isr_eoi", rv, 8'h00);
        chk("nest_int6_after_eoi", int_o, 8'h01);

        wr(1, 8'hFF); ir = 8'hFF; settle();
        chk("mask_int", int_o, 8'h00);
        rd(1, rv, ren);
        chk("mask_imr_read", rv, 8'hFF);

        ir = 8'h00; wr(1, 8'h00); settle();
        ir = 8'h40; settle();
        inta(vec, ren, mid);
        chk("spur_pre_vec", vec, 8'h96);
        ir = 8'h48; settle();
        chk("spur_int3", int_o, 8'h01);
        ir = 8'h40; settle();
        inta(vec, ren, mid);
        chk("spur_vec", vec, 8'h97);
        rd(0, rv, ren);
        chk("spur_isr", rv, 8'h40);
        wr(0, 8'h20);
        ir = 8'h00; settle();

`ifdef PIC_ROTATE_EN
        wr(0, 8'h13); wr(1, 8'h90); wr(1, 8'h00); wr(1, 8'h00); wr(0, 8'hC3);
        ir = 8'h11; settle();
        chk("rot_int", int_o, 8'h01);
        inta(vec, ren, mid);
        chk("rot_vec", vec, 8'h94);
        ir = 8'h00; settle();
`endif

        m_t = 5'($urandom);
        wr(0, 8'h1B); wr(1, {m_t, 3'b000}); wr(1, 8'h00); wr(0, 8'h0B);
        m_isr = 8'h00;
        m_base = 3'd0;
        for (int n = 0; n < 40; n++) begin
            m_imr = 8'($urandom);
            ir = 8'($urandom);
            wr(1, m_imr); settle();
            e = want_int(ir & ~m_imr, m_isr, m_base);
            chk("rnd_int", int_o, {7'd0, e});
            if (e) begin
                c = hp(ir & ~m_imr, m_base);
                inta(vec, ren, mid);
                chk("rnd_vec", vec, {m_t, 3'(c)});
                m_isr[c] = 1'b1;
            end
            rd(0, rv, ren);
            chk("rnd_isr", rv, m_isr);
            op = int'($urandom_range(0, 3));
            if (op == 1) begin
                s = hp(m_isr, m_base);
                wr(0, 8'h20);
                if (s != 8) m_isr[s] = 1'b0;
            end else if (op == 2) begin
                l = 3'($urandom_range(0, 7));
                wr(0, {5'b01100, l});
                m_isr[l] = 1'b0;
            end
`ifdef PIC_ROTATE_EN
            else if (op == 3) begin
                s = hp(m_isr, m_base);
                wr(0, 8'hA0);
                if (s != 8) begin
                    m_isr[s] = 1'b0;
                    m_base = 3'(s + 1);
                end
            end
`endif
        end
        ir = 8'h00; settle();

        wr(0, 8'h13); wr(1, 8'h90);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_int", int_o, 8'h00);
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_dout_en", dout_en, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        wr(1, 8'h5A); ir = 8'hFF; settle();
        chk("rst_ignored_int", int_o, 8'h00);
        rd(1, rv, ren);
        chk("rst_ignored_imr", rv, 8'h00);
        wr(0, 8'h13); wr(1, 8'h90); wr(1, 8'h00); wr(1, 8'h5A);
        rd(1, rv, ren);
        chk("reinit_imr", rv, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
